// File: rtl/loadable_instruction_memory_if.sv
// Load/fetch bus of the loadable instruction memory.
// The master modport belongs to the loader and fetch side, which drive load_* and fetch_*
// and program_counter. The slave modport belongs to the memory, which drives load_ready,
// the fetch results and the status outputs.
interface loadable_instruction_memory_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) ();
    logic                  load_start;
    logic [ADDR_WIDTH-1:0] load_length;
    logic                  load_valid;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  load_ready;
    logic                  fetch_enable;
    logic [ADDR_WIDTH-1:0] program_counter;
    logic [DATA_WIDTH-1:0] instruction;
    logic                  instruction_valid;
    logic                  fault;
    logic                  running;
    logic [ADDR_WIDTH-1:0] loaded_words;

    modport master (
        output load_start, load_length, load_valid, load_data,
        output fetch_enable, program_counter,
        input  load_ready, instruction, instruction_valid, fault, running, loaded_words
    );

    modport slave (
        input  load_start, load_length, load_valid, load_data,
        input  fetch_enable, program_counter,
        output load_ready, instruction, instruction_valid, fault, running, loaded_words
    );
endinterface

// File: rtl/loadable_instruction_memory.sv
// Word-addressed instruction store that is loaded at runtime.
// The loader streams program words in over a valid/ready port. The core fetches them with
// 1-cycle registered latency once the controller is in RUN.
// Ports:
//   clk_i  - system clock, all logic on the rising edge
//   rst_i  - synchronous active-high reset (the array contents are kept)
//   bus_io - slave side of the load/fetch bus:
//            load_start/load_length/load_valid/load_data in, load_ready out;
//            fetch_enable/program_counter in;
//            instruction/instruction_valid/fault/running/loaded_words out.
module loadable_instruction_memory #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           DEPTH      = 800,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    loadable_instruction_memory_if.slave  bus_io
);
    localparam int unsigned           IdxW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] DepthA = ADDR_WIDTH'(DEPTH);

    typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] count_q, count_d;
    logic [ADDR_WIDTH-1:0] target_q, target_d;
    logic [ADDR_WIDTH-1:0] loaded_q, loaded_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic                  instr_valid_q, instr_valid_d;
    logic                  fault_q, fault_d;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] count_inc;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    assign count_inc = count_q + ADDR_WIDTH'(1);

    // Controller next state and load-side bookkeeping
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        target_d = target_q;
        loaded_d = loaded_q;
        mem_we   = 1'b0;

        if (bus_io.load_start) begin
            // A start pulse takes priority over any word presented in the same cycle
            count_d  = '0;
            loaded_d = '0;
            target_d = (bus_io.load_length > DepthA) ? DepthA : bus_io.load_length;
            state_d  = (bus_io.load_length == '0) ? StRun : StLoad;
        end else begin
            unique case (state_q)
                StIdle: ;
                StLoad: begin
                    if (bus_io.load_valid) begin
                        mem_we  = 1'b1;
                        count_d = count_inc;
                        if (count_inc == target_q) begin
                            state_d  = StRun;
                            loaded_d = target_q;
                        end
                    end
                end
                StRun: ;
                default: state_d = StIdle;
            endcase
        end
    end

    // Fetch result for the next cycle
    always_comb begin
        instr_d       = instr_q;
        instr_valid_d = 1'b0;
        fault_d       = 1'b0;

        if (bus_io.load_start || (state_q != StRun)) begin
            instr_d = NOP_WORD;
        end else if (bus_io.fetch_enable) begin
            instr_valid_d = 1'b1;
            // Full-width unsigned range check first, so only in-range addresses index the array
            if (bus_io.program_counter < loaded_q) begin
                instr_d = mem_q[bus_io.program_counter[IdxW-1:0]];
            end else begin
                instr_d = NOP_WORD;
                fault_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            count_q       <= '0;
            target_q      <= '0;
            loaded_q      <= '0;
            instr_q       <= NOP_WORD;
            instr_valid_q <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            target_q      <= target_d;
            loaded_q      <= loaded_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            fault_q       <= fault_d;
        end
    end

    // The array has no reset. A write only happens in LOAD with count_q < target_q <= DEPTH.
    always_ff @(posedge clk_i) begin
        if (mem_we && !rst_i) begin
            mem_q[count_q[IdxW-1:0]] <= bus_io.load_data;
        end
    end

    assign bus_io.load_ready        = (state_q == StLoad);
    assign bus_io.instruction       = instr_q;
    assign bus_io.instruction_valid = instr_valid_q;
    assign bus_io.fault             = fault_q;
    assign bus_io.running           = (state_q == StRun);
    assign bus_io.loaded_words      = loaded_q;
endmodule
